// File: rtl/thresholding_cfg_arbiter_if.sv
// Bundles the write, read, response and cfg-port handshakes of the thresholding config arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the core.
interface thresholding_cfg_arbiter_if #(
  parameter int unsigned A_BITS = 8,
  parameter int unsigned K      = 16
) ();
  logic              wr_vld;
  logic              wr_rdy;
  logic [A_BITS-1:0] wr_a;
  logic [K-1:0]      wr_d;
  logic              wr_ack_vld;
  logic              wr_ack_rdy;
  logic              rd_vld;
  logic              rd_rdy;
  logic [A_BITS-1:0] rd_a;
  logic              rq_vld;
  logic              rq_rdy;
  logic [K-1:0]      rq_d;
  logic              cfg_en;
  logic              cfg_we;
  logic [A_BITS-1:0] cfg_a;
  logic [K-1:0]      cfg_d;
  logic              cfg_rack;
  logic [K-1:0]      cfg_q;
  logic              err;

  modport slave (
    input  wr_vld, wr_a, wr_d, wr_ack_rdy, rd_vld, rd_a, rq_rdy, cfg_rack, cfg_q,
    output wr_rdy, wr_ack_vld, rd_rdy, rq_vld, rq_d, cfg_en, cfg_we, cfg_a, cfg_d, err
  );

  modport master (
    output wr_vld, wr_a, wr_d, wr_ack_rdy, rd_vld, rd_a, rq_rdy, cfg_rack, cfg_q,
    input  wr_rdy, wr_ack_vld, rd_rdy, rq_vld, rq_d, cfg_en, cfg_we, cfg_a, cfg_d, err
  );
endinterface

// File: rtl/thresholding_cfg_arbiter.sv
// Round-robin sequencer of write/read requests onto the thresholding core cfg port, with
// credit-bounded readbacks, a show-ahead read-response FIFO and a single outstanding write ack.
module thresholding_cfg_arbiter #(
  parameter int unsigned A_BITS   = 8,
  parameter int unsigned K        = 16,
  parameter int unsigned RD_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  thresholding_cfg_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(RD_DEPTH + 1);
  localparam int unsigned PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam logic [CW-1:0] DepthC   = CW'(RD_DEPTH);
  localparam logic [CW:0]   DepthExt = (CW + 1)'(RD_DEPTH);
  localparam logic [PW-1:0] LastPtr  = PW'(RD_DEPTH - 1);

  logic              rr_wr_q;  // 1: write side wins a tie
  logic              cfg_en_q, cfg_we_q;
  logic [A_BITS-1:0] cfg_a_q;
  logic [K-1:0]      cfg_d_q;
  logic              wr_ack_vld_q;
  logic              err_q;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [K-1:0]      mem_q [RD_DEPTH];

  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic pop, push, outstanding;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_elig  = bus.wr_vld && (!wr_ack_vld_q || bus.wr_ack_rdy);
    rd_elig  = bus.rd_vld && (credit_q != '0);
    grant_wr = !rst && wr_elig && (!rd_elig || rr_wr_q);
    grant_rd = !rst && rd_elig && !grant_wr;
  end

  // Anything issued but neither returned nor buffered still belongs to the core.
  always_comb begin
    outstanding = ({1'b0, credit_q} + {1'b0, count_q}) != DepthExt;
    pop         = (count_q != '0) && bus.rq_rdy;
    push        = bus.cfg_rack && outstanding;
  end

  always_comb begin
    credit_d = credit_q;
    case ({grant_rd, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_wr_q      <= 1'b1;
      cfg_en_q     <= 1'b0;
      cfg_we_q     <= 1'b0;
      cfg_a_q      <= '0;
      cfg_d_q      <= '0;
      wr_ack_vld_q <= 1'b0;
      err_q        <= 1'b0;
      credit_q     <= DepthC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      cfg_en_q <= grant_wr || grant_rd;
      cfg_we_q <= grant_wr;
      if (grant_wr) begin
        cfg_a_q <= bus.wr_a;
        cfg_d_q <= bus.wr_d;
      end else if (grant_rd) begin
        cfg_a_q <= bus.rd_a;
        cfg_d_q <= '0;
      end else begin
        cfg_a_q <= '0;
        cfg_d_q <= '0;
      end

      if (grant_wr) begin
        rr_wr_q <= 1'b0;
      end else if (grant_rd) begin
        rr_wr_q <= 1'b1;
      end

      // A new write accepted while the old ack drains keeps the ack high without a bubble.
      if (grant_wr) begin
        wr_ack_vld_q <= 1'b1;
      end else if (bus.wr_ack_rdy) begin
        wr_ack_vld_q <= 1'b0;
      end

      if (bus.cfg_rack && !outstanding) begin
        err_q <= 1'b1;
      end

      credit_q <= credit_d;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.cfg_q;
    end
  end

  assign bus.wr_rdy     = grant_wr;
  assign bus.rd_rdy     = grant_rd;
  assign bus.wr_ack_vld = wr_ack_vld_q;
  assign bus.rq_vld     = (count_q != '0);
  assign bus.rq_d       = mem_q[rd_ptr_q];
  assign bus.cfg_en     = cfg_en_q;
  assign bus.cfg_we     = cfg_we_q;
  assign bus.cfg_a      = cfg_a_q;
  assign bus.cfg_d      = cfg_d_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_thresholding_cfg_arbiter.sv
// Directed bench for thresholding_cfg_arbiter with a fixed-latency core model whose readback
// data is {~addr, addr}. Response ordering is checked against a scoreboard of accepted reads.
module tb_thresholding_cfg_arbiter;
  localparam int unsigned LAT = 5;

  logic clk = 1'b0;
  logic rst;
  logic spur;
  always #5 clk = ~clk;

  thresholding_cfg_arbiter_if #(.A_BITS(8), .K(16)) bus ();

  thresholding_cfg_arbiter #(.A_BITS(8), .K(16), .RD_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] qfun(input logic [7:0] a);
    return {~a, a};
  endfunction

  // In-order core: readback appears LAT cycles after its cfg op; cleared by the shared reset.
  logic [LAT-1:0] pipe_v;
  logic [7:0]     pipe_a [LAT];
  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], bus.cfg_en && !bus.cfg_we};
      pipe_a[0] <= bus.cfg_a;
      for (int s = 1; s < LAT; s++) pipe_a[s] <= pipe_a[s-1];
    end
  end
  assign bus.cfg_rack = pipe_v[LAT-1] | spur;
  assign bus.cfg_q    = spur ? 16'hDEAD : qfun(pipe_a[LAT-1]);

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  int n_acc   = 0;
  int both_cnt = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.wr_rdy && bus.rd_rdy) both_cnt++;
      if (bus.rd_vld && bus.rd_rdy) exp_q.push_back(qfun(bus.rd_a));
      if (bus.rq_vld && bus.rq_rdy) begin
        n_pop++;
        if (exp_q.size() == 0) chk("rq_unexpected", 32'(exp_q.size()), 32'd1);
        else chk("rq_order", 32'(bus.rq_d), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spur = 1'b0;
    bus.wr_vld = 1'b1; bus.wr_a = '0; bus.wr_d = '0; bus.wr_ack_rdy = 1'b0;
    bus.rd_vld = 1'b1; bus.rd_a = '0; bus.rq_rdy = 1'b0;
    step(); step();
    #1;
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 0);
    chk("rst_rd_rdy", 32'(bus.rd_rdy), 0);
    chk("rst_cfg_en", 32'(bus.cfg_en), 0);
    chk("rst_cfg_we", 32'(bus.cfg_we), 0);
    chk("rst_cfg_a", 32'(bus.cfg_a), 0);
    chk("rst_cfg_d", 32'(bus.cfg_d), 0);
    chk("rst_ack", 32'(bus.wr_ack_vld), 0);
    chk("rst_rq_vld", 32'(bus.rq_vld), 0);
    chk("rst_err", 32'(bus.err), 0);

    // Alternating grants, write first after reset
    step();
    rst = 1'b0; bus.wr_ack_rdy = 1'b1; bus.rq_rdy = 1'b1; n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_a = 8'(8'h80 + i); bus.wr_d = 16'(16'h1000 + i); bus.rd_a = 8'(8'h40 + i);
      #1;
      chk("alt_rd_rdy", 32'(bus.rd_rdy), 32'(i % 2));
      chk("alt_wr_rdy", 32'(bus.wr_rdy), 32'((i + 1) % 2));
      if (i > 0) begin
        chk("alt_cfg_en", 32'(bus.cfg_en), 1);
        chk("alt_cfg_we", 32'(bus.cfg_we), 32'(i % 2));
      end
      if (i == 1) begin
        chk("alt_w_a", 32'(bus.cfg_a), 32'h80);
        chk("alt_w_d", 32'(bus.cfg_d), 32'h1000);
      end
      if (i == 2) begin
        chk("alt_r_a", 32'(bus.cfg_a), 32'h41);
        chk("alt_r_d", 32'(bus.cfg_d), 0);
      end
      step();
    end
    bus.wr_vld = 1'b0; bus.rd_vld = 1'b0;
    #1;
    chk("alt_last_en", 32'(bus.cfg_en), 1);
    chk("alt_last_a", 32'(bus.cfg_a), 32'h47);
    for (int k = 0; k < 20 && n_pop < 4; k++) step();
    chk("alt_pops", 32'(n_pop), 4);

    // Single write
    bus.wr_vld = 1'b1; bus.wr_a = 8'h12; bus.wr_d = 16'h00AB;
    #1;
    chk("w1_rdy", 32'(bus.wr_rdy), 1);
    step();
    bus.wr_vld = 1'b0;
    #1;
    chk("w1_cfg_en", 32'(bus.cfg_en), 1);
    chk("w1_cfg_we", 32'(bus.cfg_we), 1);
    chk("w1_cfg_a", 32'(bus.cfg_a), 32'h12);
    chk("w1_cfg_d", 32'(bus.cfg_d), 32'h00AB);
    chk("w1_ack", 32'(bus.wr_ack_vld), 1);
    step();
    #1;
    chk("w1_ack_clr", 32'(bus.wr_ack_vld), 0);
    chk("w1_en_clr", 32'(bus.cfg_en), 0);

    // Credit limit with a stalled response consumer
    n_pop = 0; n_acc = 0; bus.rq_rdy = 1'b0; bus.rd_vld = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.rd_a = 8'(8'h60 + n_acc);
      #1;
      if (bus.rd_rdy) n_acc++;
      step();
    end
    #1;
    chk("cr_accepted", 32'(n_acc), 4);
    chk("cr_rd_rdy", 32'(bus.rd_rdy), 0);
    chk("cr_rq_vld", 32'(bus.rq_vld), 1);
    bus.rq_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.rd_vld = (n_acc < 6); bus.rd_a = 8'(8'h60 + n_acc);
      #1;
      chk("cr_stream", 32'(bus.rq_vld), 1);
      if (bus.rd_vld && bus.rd_rdy) n_acc++;
      step();
    end
    for (int k = 0; k < 20 && n_pop < 6; k++) begin
      bus.rd_vld = (n_acc < 6); bus.rd_a = 8'(8'h60 + n_acc);
      #1;
      if (bus.rd_vld && bus.rd_rdy) n_acc++;
      step();
    end
    bus.rd_vld = 1'b0;
    chk("cr_total_acc", 32'(n_acc), 6);
    chk("cr_total_pop", 32'(n_pop), 6);

    // One outstanding write ack; consume and accept in the same cycle
    bus.wr_ack_rdy = 1'b0; bus.wr_vld = 1'b1; bus.wr_a = 8'h21; bus.wr_d = 16'h1111;
    #1;
    chk("b_first_rdy", 32'(bus.wr_rdy), 1);
    step();
    bus.wr_a = 8'h22; bus.wr_d = 16'h2222;
    #1;
    chk("b_ack_held", 32'(bus.wr_ack_vld), 1);
    chk("b_block", 32'(bus.wr_rdy), 0);
    step();
    #1;
    chk("b_block2", 32'(bus.wr_rdy), 0);
    bus.wr_ack_rdy = 1'b1;
    #1;
    chk("b_same_cyc", 32'(bus.wr_rdy), 1);
    step();
    bus.wr_vld = 1'b0;
    #1;
    chk("b_no_gap", 32'(bus.wr_ack_vld), 1);
    chk("b_cfg_a", 32'(bus.cfg_a), 32'h22);
    chk("b_cfg_d", 32'(bus.cfg_d), 32'h2222);
    step();
    #1;
    chk("b_drained", 32'(bus.wr_ack_vld), 0);

    // Spurious readback
    spur = 1'b1;
    step();
    spur = 1'b0;
    #1;
    chk("err_set", 32'(bus.err), 1);
    chk("err_no_push", 32'(bus.rq_vld), 0);
    step(); step(); step();
    #1;
    chk("err_sticky", 32'(bus.err), 1);
    chk("err_rq_idle", 32'(bus.rq_vld), 0);

    // Reset with reads in flight
    n_acc = 0; n_pop = 0; bus.rq_rdy = 1'b1; bus.rd_vld = 1'b1;
    for (int k = 0; k < 10 && n_acc < 3; k++) begin
      bus.rd_a = 8'(8'h30 + n_acc);
      #1;
      if (bus.rd_rdy) n_acc++;
      step();
    end
    bus.rd_vld = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst6_rq_vld", 32'(bus.rq_vld), 0);
    chk("rst6_cfg_en", 32'(bus.cfg_en), 0);
    chk("rst6_err", 32'(bus.err), 0);
    chk("rst6_ack", 32'(bus.wr_ack_vld), 0);
    repeat (8) step();
    #1;
    chk("rst6_dropped", 32'(bus.rq_vld), 0);
    chk("rst6_no_pop", 32'(n_pop), 0);
    n_acc = 0; bus.rq_rdy = 1'b0; bus.rd_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.rd_a = 8'(8'h50 + n_acc);
      #1;
      if (bus.rd_rdy) n_acc++;
      step();
    end
    bus.rd_vld = 1'b0;
    chk("rst6_credits", 32'(n_acc), 4);
    bus.rq_rdy = 1'b1;
    for (int k = 0; k < 30 && n_pop < 4; k++) step();
    chk("rst6_resume", 32'(n_pop), 4);
    chk("rdy_mutex", 32'(both_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
